// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and the IF/ID payload record.
`default_nettype none

package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc    = '0;
        b.pc4   = '0;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and clear-to-bubble controls.
`default_nettype none

module if_id_reg
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            valid_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);

    if_id_t r_q;
    if_id_t r_d;

    // Clear outranks hold so a squash always lands even while stalled.
    always_comb begin
        r_d = r_q;
        if (clear_i) begin
            r_d = if_id_bubble();
        end else if (!hold_i) begin
            r_d.pc    = pc_i;
            r_d.pc4   = pc4_i;
            r_d.instr = instr_i;
            r_d.valid = valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= if_id_bubble();
        end else begin
            r_q <= r_d;
        end
    end

    assign pc_o    = r_q.pc;
    assign pc4_o   = r_q.pc4;
    assign instr_o = r_q.instr;
    assign valid_o = r_q.valid;

endmodule

`default_nettype wire

// File: rtl/fetch_if_id.sv
// fetch_if_id: RV32I fetch stage (PC, imem request) feeding the IF/ID register.
`default_nettype none

module fetch_if_id
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    input  logic             imem_ready_i,
    output logic [31:0]      if_id_pc_o,
    output logic [31:0]      if_id_pc4_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_valid_o,
    output logic [6:0]       opcode_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  pc_plus4;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             bubble;
    logic             ifid_hold;
    logic             unused_redir_lo;

    assign pc_plus4        = pc_q + 32'd4;
    assign unused_redir_lo = ^redirect_pc_i[1:0];

    // A bubble enters IF/ID on a squash, or when memory stalls without a hazard stall.
    assign bubble    = flush_i | (~stall_i & ~imem_ready_i);
    assign ifid_hold = stall_i & ~flush_i;

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (!stall_i && imem_ready_i) begin
            pc_d = pc_plus4;
        end
        if (bubble) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (ifid_hold),
        .clear_i (bubble),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .instr_i (imem_rdata_i),
        .valid_i (1'b1),
        .pc_o    (if_id_pc_o),
        .pc4_o   (if_id_pc4_o),
        .instr_o (if_id_instr_o),
        .valid_o (if_id_valid_o)
    );

    assign imem_req_o   = ~rst;
    assign imem_addr_o  = pc_q;
    assign opcode_o     = if_id_instr_o[6:0];
    assign bubble_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_if_id.sv
// tb_fetch_if_id: directed literal checks plus randomized run against a behavioural model.
`default_nettype none

module tb_fetch_if_id;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ready;
    logic [31:0] redir;
    logic        req;
    logic [31:0] addr, rdata, ipc, ipc4, iins;
    logic        ival;
    logic [6:0]  opc;
    logic [15:0] cnt;

    logic        rst2;
    logic        req2;
    logic [31:0] addr2, rdata2, ipc2, ipc4_2, iins2;
    logic        ival2;
    logic [6:0]  opc2;
    logic [15:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0000_0033;
            32'h4: return 32'h0000_0003;
            32'h8: return 32'h0000_0013;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign rdata  = mem_word(addr);
    assign rdata2 = mem_word(addr2);

    fetch_if_id #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .redirect_pc_i(redir),
        .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata), .imem_ready_i(ready),
        .if_id_pc_o(ipc), .if_id_pc4_o(ipc4), .if_id_instr_o(iins), .if_id_valid_o(ival),
        .opcode_o(opc), .bubble_cnt_o(cnt)
    );

    fetch_if_id #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst2), .stall_i(1'b0), .flush_i(1'b0), .redirect_pc_i(32'h0),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2), .imem_ready_i(1'b1),
        .if_id_pc_o(ipc2), .if_id_pc4_o(ipc4_2), .if_id_instr_o(iins2), .if_id_valid_o(ival2),
        .opcode_o(opc2), .bubble_cnt_o(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: architectural state of the fetch stage.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_ins;
    logic        m_val;
    logic [15:0] m_cnt;
    bit          m_known = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_ins = 32'h13; m_val = 0; m_cnt = 0;
            m_known = 1;
        end else if (flush) begin
            m_pc  = redir & 32'hFFFF_FFFC;
            m_ipc = 0; m_ipc4 = 0; m_ins = 32'h13; m_val = 0;
            m_cnt = m_cnt + 16'd1;
        end else if (stall) begin
            // everything holds
        end else if (!ready) begin
            m_ipc = 0; m_ipc4 = 0; m_ins = 32'h13; m_val = 0;
            m_cnt = m_cnt + 16'd1;
        end else begin
            m_ipc  = m_pc;
            m_ipc4 = m_pc + 32'd4;
            m_ins  = mem_word(m_pc);
            m_val  = 1;
            m_pc   = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("m_req",   {31'b0, req},  {31'b0, ~rst});
            chk("m_addr",  addr,          m_pc);
            chk("m_pc",    ipc,           m_ipc);
            chk("m_pc4",   ipc4,          m_ipc4);
            chk("m_instr", iins,          m_ins);
            chk("m_valid", {31'b0, ival}, {31'b0, m_val});
            chk("m_opc",   {25'b0, opc},  {25'b0, m_ins[6:0]});
            chk("m_cnt",   {16'b0, cnt},  {16'b0, m_cnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; rst2 = 1; stall = 0; flush = 0; ready = 1; redir = 0;
        tick(); tick();
        chk("rst_addr",  addr, 32'h0);
        chk("rst_valid", {31'b0, ival}, 32'h0);
        chk("rst_instr", iins, 32'h13);
        chk("rst_cnt",   {16'b0, cnt}, 32'h0);
        chk("rst_req",   {31'b0, req}, 32'h0);
        chk("rst2_addr", addr2, 32'hFFFF_FFFC);

        // Straight-line fetch from 0
        rst = 0; rst2 = 0;
        tick();
        chk("f0_pc",   ipc, 32'h0);
        chk("f0_opc",  {25'b0, opc}, 32'h33);
        chk("f0_val",  {31'b0, ival}, 32'h1);
        chk("f0_addr", addr, 32'h4);
        chk("w_pc",    ipc2, 32'hFFFF_FFFC);
        chk("w_pc4",   ipc4_2, 32'h0);
        chk("w_addr",  addr2, 32'h0);
        tick();
        chk("f1_pc",   ipc, 32'h4);
        chk("f1_opc",  {25'b0, opc}, 32'h03);
        chk("f1_addr", addr, 32'h8);
        chk("w2_addr", addr2, 32'h4);
        chk("w2_pc",   ipc2, 32'h0);

        // Two-cycle stall
        stall = 1;
        tick(); tick();
        chk("st_addr", addr, 32'h8);
        chk("st_pc",   ipc, 32'h4);
        chk("st_val",  {31'b0, ival}, 32'h1);
        chk("st_cnt",  {16'b0, cnt}, 32'h0);
        stall = 0;
        tick();
        chk("rel_pc",  ipc, 32'h8);
        chk("rel_opc", {25'b0, opc}, 32'h13);
        chk("rel_addr", addr, 32'hC);

        // Flush during stall, misaligned target
        flush = 1; stall = 1; redir = 32'h0000_0103;
        tick();
        chk("fl_addr", addr, 32'h100);
        chk("fl_val",  {31'b0, ival}, 32'h0);
        chk("fl_opc",  {25'b0, opc}, 32'h13);
        chk("fl_cnt",  {16'b0, cnt}, 32'h1);
        flush = 0; stall = 0;
        tick();
        chk("fl_cap_pc", ipc, 32'h100);
        chk("fl_cap_val", {31'b0, ival}, 32'h1);

        // Memory not ready at 0x20
        flush = 1; redir = 32'h20;
        tick();
        flush = 0; ready = 0;
        tick(); tick(); tick();
        chk("nr_addr", addr, 32'h20);
        chk("nr_val",  {31'b0, ival}, 32'h0);
        chk("nr_cnt",  {16'b0, cnt}, 32'h5);
        ready = 1;
        tick();
        chk("nr_pc",    ipc, 32'h20);
        chk("nr_instr", iins, mem_word(32'h20));

        // Reset while stalled and flushing
        stall = 1; flush = 1; rst = 1;
        tick();
        chk("rr_addr",  addr, 32'h0);
        chk("rr_val",   {31'b0, ival}, 32'h0);
        chk("rr_instr", iins, 32'h13);
        chk("rr_cnt",   {16'b0, cnt}, 32'h0);
        rst = 0; stall = 0; flush = 0;

        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            ready = ($urandom_range(0, 3) != 0);
            redir = $urandom;
            rst   = ($urandom_range(0, 96) == 0);
            tick();
        end
        rst = 0; stall = 0; flush = 0; ready = 1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_if_id.md
Name: fetch_if_id

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the RV32I 5-stage pipeline.
- Holds the PC and issues instruction-memory addresses.
- Latches the fetched word with its PC into the IF/ID register.
- Drives the opcode field straight into type_decoder in ID.
- Honours load-use stalls from the hazard unit, branch/jump redirects resolved in EX, and memory not-ready cycles (which insert bubbles).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the bubble performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall_i  in  1  hazard unit load-use stall; hold PC and IF/ID
flush_i  in  1  EX-resolved taken branch/jump; redirect and squash
redirect_pc_i  in  32  target PC, valid when flush_i=1
imem_req_o  out  1  fetch request, =~rst
imem_addr_o  out  32  current PC, combinational from PC register
imem_rdata_i  in  32  instruction word, same-cycle response
imem_ready_i  in  1  imem_rdata_i valid this cycle
if_id_pc_o  out  32  PC of instruction held in IF/ID
if_id_pc4_o  out  32  that PC + 4 (link value for jal/jalr)
if_id_instr_o  out  32  instruction held in IF/ID
if_id_valid_o  out  1  IF/ID holds a real instruction
opcode_o  out  7  if_id_instr_o[6:0], to type_decoder
bubble_cnt_o  out  CNT_W  count of bubbles inserted into IF/ID

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled only on the rising edge.
- Reset values:
  - pc = RESET_PC
  - if_id_pc_o = 0, if_id_pc4_o = 0
  - if_id_instr_o = 32'h0000_0013 (NOP, addi x0,x0,0), so opcode_o = 7'h13
  - if_id_valid_o = 0, bubble_cnt_o = 0
- Per-edge priority: rst > flush_i > stall_i > imem not ready > normal fetch.
- flush_i=1 (regardless of stall_i and imem_ready_i):
  - pc <= {redirect_pc_i[31:2], 2'b00}; low bits are silently cleared.
  - IF/ID <= bubble (instr NOP, valid 0, pc/pc4 0).
  - bubble_cnt increments.
- stall_i=1, flush_i=0: pc and all IF/ID outputs hold. Fetched data is discarded and refetched next cycle; the counter holds.
- imem_ready_i=0, no flush/stall: pc holds; IF/ID <= bubble; bubble_cnt increments.
- Normal (ready, no flush/stall):
  - pc <= pc+4.
  - IF/ID <= {pc, pc+4, imem_rdata_i, valid 1}.
- Latency: a word at address A appears on if_id_instr_o one cycle after A was on imem_addr_o with ready high.
- Arithmetic:
  - pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, and if_id_pc4_o = 0 for that instruction.
  - bubble_cnt wraps from all-ones to 0.
- The first cycle after reset deassertion fetches RESET_PC.
- Reset mid-stall or mid-flush: reset wins and the state returns to reset values on that edge.
- No combinational path from stall_i/flush_i to any output except through registers. imem_addr_o depends only on the PC register.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN=32
  - NOP_INSTR=32'h0000_0013
  - opcode constants: OPC_R=7'h33, OPC_LOAD=7'h03, OPC_OPIMM=7'h13, OPC_JALR=7'h67, OPC_STORE=7'h23, OPC_BRANCH=7'h63, OPC_AUIPC=7'h17, OPC_LUI=7'h37, OPC_JAL=7'h6f
  - type_decoder shares these constants.
- Sub-module if_id_reg holds pc/pc4/instr/valid with hold (stall) and clear (bubble) controls. The PC register and counter stay in fetch_if_id.

Test Plan:
1. Reset then ready=1 with imem returning 32'h0000_0033, 32'h0000_0003, 32'h0000_0013 at 0, 4, 8 -> imem_addr_o 0, 4, 8, 12. if_id_instr_o follows one cycle behind with pc 0, 4, 8; opcode_o 7'h33, 7'h03, 7'h13; valid 1; bubble_cnt_o 0.
2. stall_i high for 2 cycles with IF/ID holding pc=4 -> imem_addr_o stays 8; if_id_pc_o stays 4 with valid 1. After release the next IF/ID pc is 8; bubble_cnt unchanged.
3. flush_i=1 with redirect_pc_i=32'h0000_0103 while stall_i=1 -> next edge gives imem_addr_o=32'h0000_0100, if_id_valid_o=0, opcode_o=7'h13, bubble_cnt +1. The following edge captures pc 0x100.
4. imem_ready_i=0 for 3 cycles at pc=0x20 -> imem_addr_o holds 0x20; valid 0 for 3 cycles; bubble_cnt +3. With ready=1 the word at 0x20 enters IF/ID.
5. RESET_PC=32'hFFFF_FFFC, run 2 fetches -> if_id_pc_o=0xFFFF_FFFC with if_id_pc4_o=0, then imem_addr_o wraps to 0x0000_0004.
6. Assert rst mid-stall with flush_i=1 -> next edge gives pc=RESET_PC, valid 0, instr NOP, bubble_cnt 0.
